// File: rtl/csel_sub_seq.sv
// -----------------------------------------------------------------------------
// csel_sub_seq
//
// Nibble-serial carry-select subtractor. It computes diff = a - b (mod 2^WIDTH)
// one 4-bit nibble per clock, least significant nibble first. Each cycle forms
// both carry-in candidates of a_nib + ~b_nib + cin. The carry registered from
// the previous nibble picks one of them. The initial carry of 1 provides the
// +1 of the two's complement.
//
// Optional feature macro: CSEL_SUB_OVF_EN
//   defined   -> ovf port and its register exist (signed overflow flag)
//   undefined -> ovf port, register and logic are absent
//
// Parameters
//   WIDTH      operand/result width, a multiple of 4 and >= 4
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       minuend / subtrahend (sampled only on the accept edge)
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   diff       a - b modulo 2^WIDTH
//   borrow     1 when a < b (unsigned)
//   zero       1 when diff == 0
//   ovf        signed overflow of a - b (CSEL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module csel_sub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef CSEL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int NIB_CNT = WIDTH / 4;
  localparam int IDX_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One nibble candidate: x + ~y + cin, kept 5 bits wide so bit 4 is carry-out.
  function automatic logic [4:0] nib_sum(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       cin);
    nib_sum = {1'b0, x} + {1'b0, ~y} + {4'b0000, cin};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               in_ready_nxt_s;
  logic               out_valid_nxt_s;

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r;
  logic               zero_r;
`ifdef CSEL_SUB_OVF_EN
  logic               ovf_r;
`endif

  logic               accept_s;
  logic               last_s;
  logic [3:0]         a_nib_s;
  logic [3:0]         b_nib_s;
  logic [4:0]         s0_s;
  logic [4:0]         s1_s;
  logic [4:0]         sel_s;
  logic [WIDTH-1:0]   diff_nxt_s;

  assign accept_s = in_valid && (state_r == ST_IDLE);
  assign last_s   = (idx_r == IDX_W'(NIB_CNT - 1));

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        // Handshake returns to IDLE only; no accept in this same cycle.
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the flags can be registered.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    out_valid_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b0;
      end
      ST_RUN: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
      end
      ST_DONE: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b1;
      end
      default: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake flags. They always equal the decode of state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Nibble datapath
  // ---------------------------------------------------------------------------

  // Select the current nibble pair and merge the chosen sum into the result.
  // Constant-index slices keep every select at its natural width.
  always_comb begin
    a_nib_s    = 4'h0;
    b_nib_s    = 4'h0;
    diff_nxt_s = diff_r;
    for (int n = 0; n < NIB_CNT; n++) begin
      a_nib_s = a_nib_s | ((idx_r == IDX_W'(n)) ? a_r[4*n +: 4] : 4'h0);
      b_nib_s = b_nib_s | ((idx_r == IDX_W'(n)) ? b_r[4*n +: 4] : 4'h0);
    end
    s0_s  = nib_sum(a_nib_s, b_nib_s, 1'b0);
    s1_s  = nib_sum(a_nib_s, b_nib_s, 1'b1);
    sel_s = carry_r ? s1_s : s0_s;
    for (int n = 0; n < NIB_CNT; n++) begin
      diff_nxt_s[4*n +: 4] = (idx_r == IDX_W'(n)) ? sel_s[3:0] : diff_r[4*n +: 4];
    end
  end

  // Operand capture, per-nibble progress and the final result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
`ifdef CSEL_SUB_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= 1'b1;
      idx_r   <= {IDX_W{1'b0}};
      diff_r  <= {WIDTH{1'b0}};
    end else if (state_r == ST_RUN) begin
      diff_r  <= diff_nxt_s;
      carry_r <= sel_s[4];
      idx_r   <= idx_r + IDX_W'(1);
      if (last_s) begin
        // No carry out of the top nibble means a borrow was taken.
        borrow_r <= ~sel_s[4];
        zero_r   <= (diff_nxt_s == {WIDTH{1'b0}});
`ifdef CSEL_SUB_OVF_EN
        ovf_r    <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                    (diff_nxt_s[WIDTH-1] != a_r[WIDTH-1]);
`endif
      end else begin
        borrow_r <= borrow_r;
        zero_r   <= zero_r;
      end
    end else begin
      // IDLE without accept, or DONE: hold everything for the consumer.
      carry_r <= carry_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign borrow    = borrow_r;
  assign zero      = zero_r;
`ifdef CSEL_SUB_OVF_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: doc/csel_sub_seq.md
# csel_sub_seq

Sequential nibble-serial carry-select subtractor computing unsigned difference `a - b` over a WIDTH-bit operand pair, one 4-bit nibble per clock, least significant nibble first. Each nibble cycle evaluates both carry-in candidates of `a_nib + ~b_nib + cin` and selects one using the registered carry from the previous nibble. The block is the inverse-operation companion to the adder library. It sits behind a valid/ready operand port and presents a registered result on a valid/ready result port.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and ≥4; NIB_CNT = WIDTH/4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  `a - b` modulo 2^WIDTH
- borrow  output  1  1 when a < b (unsigned)
- zero  output  1  1 when diff == 0
- ovf  output  1  signed overflow (present only with CSEL_SUB_OVF_EN)

## Operation
- One clock; reset is asynchronous and active-low.
- States:
  - IDLE: in_ready=1.
  - RUN: processes nibble `idx`.
  - DONE: out_valid=1.
- IDLE → RUN on `in_valid && in_ready`:
  - latch a, b into operand registers;
  - carry register ← 1 (two's-complement +1);
  - idx ← 0;
  - clear diff register.
- RUN, each cycle:
  - s0 = a_nib + ~b_nib + 0 and s1 = a_nib + ~b_nib + 1, both 5 bits;
  - select s1 if carry=1, else s0;
  - diff[4*idx+3 : 4*idx] ← selected[3:0];
  - carry ← selected[4];
  - idx ← idx+1.
- RUN → DONE after the cycle with idx = NIB_CNT-1.
- Results on entering DONE:
  - borrow = ~carry;
  - zero = (diff == 0);
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- DONE → IDLE on `out_valid && out_ready`. No operand accept in the same cycle.
- Operand inputs are ignored outside the accept cycle. Changes on a/b during RUN have no effect.
- in_valid while not in IDLE is ignored. The upstream holds in_valid until in_ready.
- diff, borrow, zero and ovf are registered, and remain stable throughout DONE until the handshake.
- Values of diff, borrow, zero and ovf are don't-care outside DONE. The implementation holds the last values.
- Width rule: internal nibble sums are 5 bits; no sign extension; ~b is the bitwise inverse of the latched b.

## Timing
- Reset values:
  - state=IDLE;
  - in_ready=1;
  - out_valid=0;
  - diff=0, borrow=0, zero=0, ovf=0;
  - carry=0, idx=0.
- Accept edge T0. RUN covers edges T1…T(NIB_CNT). out_valid is high after edge T(NIB_CNT), i.e. NIB_CNT cycles after accept (WIDTH=8: 2 cycles).
- Minimum initiation interval: NIB_CNT+2 cycles, covering accept, RUN, the DONE handshake cycle, and the return to IDLE.
- out_ready held low keeps DONE and all outputs indefinitely.
- Reset asserted in any state aborts immediately: outputs return to reset values, and the in-flight operation is discarded with no result produced.
- Reset deassertion: first accept possible on the first rising edge with rst_n high.

## Configuration
- CSEL_SUB_OVF_EN defined:
  - `ovf` port and its register exist;
  - computed as above;
  - reset 0.
- Undefined: `ovf` port, register and logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C → out_valid 2 cycles after accept; diff=0x1E, borrow=0, zero=0, ovf=0.
- a=0x10, b=0x20 → diff=0xF0, borrow=1, zero=0. Nibble 0 carry selects the s1 path, proving inter-nibble carry-select.
- a=0x00, b=0x00 → diff=0x00, borrow=0, zero=1. With macro: a=0x80, b=0x01 → diff=0x7F, ovf=1.
- Backpressure:
  - hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands driven;
  - diff, borrow and zero stay unchanged and in_ready stays 0;
  - after out_ready=1, IDLE next cycle, then the new operands are accepted.
- Operand change mid-RUN:
  - accept a=0xFF, b=0x01, then drive a=0x00 during RUN;
  - result diff=0xFE, borrow=0.
- Reset abort:
  - assert rst_n=0 during RUN (WIDTH=16 at idx=2);
  - out_valid=0 and in_ready=1 immediately;
  - no spurious out_valid after release;
  - next op a=0x1234, b=0x0235 → diff=0x0FFF.
